// File: rtl/ssd_display_arbiter.sv
// Round-robin owner arbitration for the shared four-digit seven-segment display.
// Three requesters compete for the display. Each owner is guaranteed a minimum
// dwell before a contender can take over. With no owner, a blank word is shown.
module ssd_display_arbiter #(
  parameter int unsigned DWELL      = 1000,
  parameter logic [19:0] BLANK_WORD = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [19:0] data0,
  input  logic [19:0] data1,
  input  logic [19:0] data2,
  output logic [2:0]  grant,
  output logic [19:0] ssd_word,
  output logic        switched
);

  localparam int unsigned WORD_W = 20;
  localparam int unsigned CNT_W  = $clog2(DWELL) + 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  // The one-hot owner encoding doubles as the grant output.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_OWN0 = 3'b001,
    ST_OWN1 = 3'b010,
    ST_OWN2 = 3'b100
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        last_owner, last_nx;
  logic [CNT_W-1:0]  dwell_cnt, cnt_nx;
  logic [WORD_W-1:0] word_nx;
  logic              switched_nx;
  logic [1:0]        own_idx;
  logic [2:0]        cand;
  logic              dwell_done;

  // First requesting index in the order s+1, s+2, then s itself only when incl is set.
  function automatic logic [2:0] pick(input logic [2:0] r, input logic [1:0] s,
                                      input logic incl);
    logic [2:0] g;
    logic [1:0] idx;
    g = 3'b000;
    for (int i = 3; i >= 1; i--) begin
      idx = 2'((int'(s) + i) % 3);
      if (r[idx] && (i != 3 || incl)) g = 3'b001 << idx;
    end
    return g;
  endfunction

  // Index of the current owner; only meaningful when a grant is held.
  function automatic logic [1:0] owner_idx(input state_t s);
    case (s)
      ST_OWN1: owner_idx = 2'd1;
      ST_OWN2: owner_idx = 2'd2;
      default: owner_idx = 2'd0;
    endcase
  endfunction

  assign dwell_done = (dwell_cnt >= DWELL_LAST);

  // Next owner, dwell accounting, and the word/pulse to register for next cycle.
  always_comb begin
    state_nx    = state;
    last_nx     = last_owner;
    cnt_nx      = dwell_cnt;
    own_idx     = owner_idx(state);
    cand        = pick(req, own_idx, 1'b0);
    word_nx     = BLANK_WORD;
    switched_nx = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (|req) state_nx = state_t'(pick(req, last_owner, 1'b1));
      end
      default: begin
        if (!req[own_idx]) begin
          // Owner released: hand over immediately or fall back to idle.
          last_nx  = own_idx;
          state_nx = state_t'(cand);
          cnt_nx   = '0;
        end else if (dwell_done && (|cand)) begin
          // Dwell served and someone else is waiting: rotate.
          last_nx  = own_idx;
          state_nx = state_t'(cand);
          cnt_nx   = '0;
        end else if (!dwell_done) begin
          cnt_nx = dwell_cnt + CNT_W'(1);
        end
      end
    endcase

    case (state_nx)
      ST_OWN0: word_nx = data0;
      ST_OWN1: word_nx = data1;
      ST_OWN2: word_nx = data2;
      default: word_nx = BLANK_WORD;
    endcase

    switched_nx = (state_nx != state);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_owner <= 2'd2;
      dwell_cnt  <= '0;
      ssd_word   <= BLANK_WORD;
      switched   <= 1'b0;
    end else begin
      state      <= state_nx;
      last_owner <= last_nx;
      dwell_cnt  <= cnt_nx;
      ssd_word   <= word_nx;
      switched   <= switched_nx;
    end
  end

  assign grant = state;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Directed self-checking bench: a long-dwell arbiter (DWELL=1000) and a
// short-dwell one (DWELL=4) receive the same stimulus.
module tb_ssd_display_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [19:0] data0, data1, data2;
  logic [2:0]  grant_l, grant_s;
  logic [19:0] word_l, word_s;
  logic        sw_l, sw_s;

  int total = 0;
  int bad   = 0;
  int pulses;
  int wrong;
  int owner;

  always #5 clk = ~clk;

  ssd_display_arbiter #(.DWELL(1000), .BLANK_WORD(20'hFFFFF)) dut_long (
    .clk(clk), .rst_n(rst_n), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .grant(grant_l), .ssd_word(word_l), .switched(sw_l)
  );

  ssd_display_arbiter #(.DWELL(4), .BLANK_WORD(20'hFFFFF)) dut_short (
    .clk(clk), .rst_n(rst_n), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .grant(grant_s), .ssd_word(word_s), .switched(sw_s)
  );

  // Advance one rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 3'b111;
    data0 = 20'h00001;
    data1 = 20'h00002;
    data2 = 20'h00003;

    // Reset held for two edges with all requests high.
    step();
    step();
    chk("rst_grant_l", 20'(grant_l), 20'h0);
    chk("rst_word_l", word_l, 20'hFFFFF);
    chk("rst_sw_l", 20'(sw_l), 20'h0);
    chk("rst_grant_s", 20'(grant_s), 20'h0);
    chk("rst_word_s", word_s, 20'hFFFFF);

    // First edge out of reset grants requester 0.
    rst_n = 1'b1;
    step();
    chk("first_grant_l", 20'(grant_l), 20'h1);
    chk("first_sw_l", 20'(sw_l), 20'h1);
    chk("first_word_l", word_l, 20'h00001);
    chk("first_grant_s", 20'(grant_s), 20'h1);

    // Short dwell rotation: each owner holds exactly 4 cycles.
    for (int t = 1; t <= 12; t++) begin
      step();
      owner = (t / 4) % 3;
      chk("rot_grant_s", 20'(grant_s), 20'(3'b001 << owner));
      chk("rot_word_s", word_s, 20'(owner + 1));
      chk("rot_sw_s", 20'(sw_s), 20'((t % 4) == 0));
    end
    chk("rot_hold_long", 20'(grant_l), 20'h1);

    // Early release under a long dwell.
    rst_n = 1'b0;
    req   = 3'b001;
    step();
    rst_n = 1'b1;
    step();
    chk("er_grant0", 20'(grant_l), 20'h1);
    repeat (9) step();
    req = 3'b011;
    repeat (10) step();
    chk("er_contended_hold", 20'(grant_l), 20'h1);
    req = 3'b010;
    step();
    chk("er_grant1", 20'(grant_l), 20'h2);
    chk("er_word1", word_l, 20'h00002);
    chk("er_sw", 20'(sw_l), 20'h1);

    // Sole requester keeps the display with no switch pulses.
    pulses = 0;
    wrong  = 0;
    for (int c = 0; c < 5000; c++) begin
      step();
      if (sw_l) pulses++;
      if (grant_l !== 3'b010) wrong++;
    end
    chk("sole_pulses", 20'(pulses), 20'h0);
    chk("sole_wrong_grant", 20'(wrong), 20'h0);
    chk("sole_grant_s", 20'(grant_s), 20'h2);
    data1 = 20'h12345;
    chk("sole_word_before", word_l, 20'h00002);
    step();
    chk("sole_word_after", word_l, 20'h12345);

    // All requests drop: blank next cycle.
    req = 3'b000;
    step();
    chk("idle_grant_l", 20'(grant_l), 20'h0);
    chk("idle_word_l", word_l, 20'hFFFFF);
    chk("idle_sw_l", 20'(sw_l), 20'h1);
    chk("idle_grant_s", 20'(grant_s), 20'h0);
    step();
    chk("idle_sw_clear", 20'(sw_l), 20'h0);

    // Return from idle with requester 2 alone.
    req = 3'b100;
    step();
    chk("ret_grant2", 20'(grant_l), 20'h4);
    chk("ret_word2", word_l, 20'h00003);

    // Owner releases as another requests at the same edge: no idle gap.
    req = 3'b010;
    step();
    chk("swap_grant1", 20'(grant_l), 20'h2);
    chk("swap_word1", word_l, 20'h12345);
    chk("swap_sw", 20'(sw_l), 20'h1);

    // Reset in the middle of a dwell.
    repeat (500) step();
    chk("mid_grant1", 20'(grant_l), 20'h2);
    rst_n = 1'b0;
    req   = 3'b111;
    step();
    chk("mid_rst_grant", 20'(grant_l), 20'h0);
    chk("mid_rst_word", word_l, 20'hFFFFF);
    chk("mid_rst_sw", 20'(sw_l), 20'h0);
    rst_n = 1'b1;
    step();
    chk("mid_restart_grant", 20'(grant_l), 20'h1);
    chk("mid_restart_word", word_l, 20'h00001);
    chk("mid_restart_sw", 20'(sw_l), 20'h1);

    // Sole requester equal to the reset last owner is still granted.
    rst_n = 1'b0;
    req   = 3'b100;
    step();
    rst_n = 1'b1;
    step();
    chk("last_owner_grant_l", 20'(grant_l), 20'h4);
    chk("last_owner_grant_s", 20'(grant_s), 20'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
